mem_wb_lsu: RTL and testbench

//  MEM/WB stage directly downstream of execute. Consumes s_lsu_op_t and s_ex_mem_wb_t from execute.

---
 rtl/mem_wb_lsu_pkg.sv | 63 ++++++
 rtl/mem_wb_lsu_align.sv | 61 ++++++
 rtl/mem_wb_lsu.sv | 169 ++++++++++++++++
 tb/tb_mem_wb_lsu.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_lsu_pkg.sv
// Shared types for the MEM/WB load-store stage: op encodings, request record, trap causes.
// No logic, no latency.
// No flow control; types only.
package mem_wb_lsu_pkg;

  typedef logic [31:0] rdata_t;
  typedef logic [4:0]  raddr_t;

  typedef enum logic [1:0] {
    NO_LSU    = 2'd0,
    LSU_LOAD  = 2'd1,
    LSU_STORE = 2'd2
  } lsu_op_typ_t;

  // BU/HU are zero-extending loads; stores treat them like B/H
  typedef enum logic [2:0] {
    LSU_B  = 3'd0,
    LSU_H  = 3'd1,
    LSU_W  = 3'd2,
    LSU_BU = 3'd3,
    LSU_HU = 3'd4
  } lsu_width_t;

  typedef struct packed {
    lsu_op_typ_t op_typ;
    lsu_width_t  width;
    logic [31:0] addr;
    logic [31:0] wdata;
  } s_lsu_op_t;

  typedef struct packed {
    rdata_t result;
    raddr_t rd_addr;
    logic   we_rd;
  } s_ex_mem_wb_t;

  typedef struct packed {
    logic [31:0] mcause;
    logic [31:0] mtval;
  } s_trap_info_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_fsm_t;

  // Request captured in IDLE and held for the whole transaction
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
    lsu_width_t  width;
  } s_lsu_req_t;

  localparam logic [31:0] MCAUSE_LD_MISALIGN = 32'd4;
  localparam logic [31:0] MCAUSE_LD_FAULT    = 32'd5;
  localparam logic [31:0] MCAUSE_ST_MISALIGN = 32'd6;
  localparam logic [31:0] MCAUSE_ST_FAULT    = 32'd7;

endpackage

// File: rtl/mem_wb_lsu_align.sv
// Byte-lane helper: alignment check, store strobes/lane replication, load extract and extension.
// Purely combinational, zero latency.
// No flow control.
module mem_wb_lsu_align
  import mem_wb_lsu_pkg::*;
(
  input  lsu_width_t  op_width,
  input  logic [1:0]  op_offs,
  input  logic [31:0] op_wdata,
  output logic        aligned,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  input  lsu_width_t  ld_width,
  input  logic [1:0]  ld_offs,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: alignment, strobes and data replicated onto every lane
  always_comb begin
    aligned = 1'b1;
    strb    = 4'hF;
    wdata   = op_wdata;
    case (op_width)
      LSU_B, LSU_BU: begin
        strb  = 4'b0001 << op_offs;
        wdata = {4{op_wdata[7:0]}};
      end
      LSU_H, LSU_HU: begin
        aligned = ~op_offs[0];
        strb    = 4'b0011 << op_offs;
        wdata   = {2{op_wdata[15:0]}};
      end
      default: begin
        aligned = (op_offs == 2'b00);
      end
    endcase
  end

  // Load side: pick the addressed byte/half from the full bus word, then extend
  always_comb begin
    case (ld_offs)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_offs[1] ? rdata[31:16] : rdata[15:0];
    case (ld_width)
      LSU_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LSU_BU:  ld_data = {24'd0, ld_byte};
      LSU_H:   ld_data = {{16{ld_half[15]}}, ld_half};
      LSU_HU:  ld_data = {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_lsu.sv
// MEM/WB stage: one load/store at a time on a valid/ready bus, write-back mux, misalign/bus-error traps.
// Zero-wait load: op seen cycle 0, request cycle 1, response cycle 2, DONE cycle 3, RF write cycle 4.
// Holds execute via lsu_bp_o from op acceptance until DONE; request held stable until dreq_ready_i.
module mem_wb_lsu
  import mem_wb_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  s_ex_mem_wb_t ex_mem_wb_i,
  input  s_lsu_op_t    lsu_i,
  output logic         lsu_bp_o,
  output rdata_t       wb_value_o,
  output logic         rf_we_o,
  output raddr_t       rf_waddr_o,
  output rdata_t       rf_wdata_o,
  output logic         dreq_valid_o,
  input  logic         dreq_ready_i,
  output logic [31:0]  dreq_addr_o,
  output logic         dreq_we_o,
  output logic [31:0]  dreq_wdata_o,
  output logic [3:0]   dreq_strb_o,
  input  logic         drsp_valid_i,
  input  logic [31:0]  drsp_rdata_i,
  input  logic         drsp_err_i,
  output logic         lsu_trap_o,
  output s_trap_info_t trap_info_o
);

  lsu_fsm_t         state_ff, state_nxt;
  s_lsu_req_t       req_ff;
  logic [CNT_W-1:0] cnt_ff;
  logic             err_ff;
  logic             load_wb_ff;
  logic             kill_ff;
  rdata_t           load_data_ff;

  logic             op_vld;
  logic             op_aligned;
  logic [3:0]       op_strb;
  logic [31:0]      op_wdata;
  rdata_t           ld_ext;
  logic             timeout;
  logic             rsp_hit;
  logic             rsp_err;

  assign op_vld = (lsu_i.op_typ != NO_LSU);

  mem_wb_lsu_align u_align (
    .op_width (lsu_i.width),
    .op_offs  (lsu_i.addr[1:0]),
    .op_wdata (lsu_i.wdata),
    .aligned  (op_aligned),
    .strb     (op_strb),
    .wdata    (op_wdata),
    .ld_width (req_ff.width),
    .ld_offs  (req_ff.addr[1:0]),
    .rdata    (drsp_rdata_i),
    .ld_data  (ld_ext)
  );

  // A silent bus is turned into an error response once the counter reaches the limit
  assign timeout = (TIMEOUT_CYC != 0) && (cnt_ff == CNT_W'(TIMEOUT_CYC));
  assign rsp_hit = drsp_valid_i || timeout;
  assign rsp_err = timeout || drsp_err_i;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_ff <= IDLE;
    end else begin
      state_ff <= state_nxt;
    end
  end

  // Next state, stall and trap outputs
  always_comb begin
    state_nxt   = state_ff;
    lsu_bp_o    = 1'b0;
    lsu_trap_o  = 1'b0;
    trap_info_o = '0;
    case (state_ff)
      IDLE: begin
        if (op_vld) begin
          if (op_aligned) begin
            lsu_bp_o  = 1'b1;
            state_nxt = REQ;
          end else begin
            // Misaligned ops never reach the bus and do not stall execute
            lsu_trap_o         = 1'b1;
            trap_info_o.mcause = (lsu_i.op_typ == LSU_STORE) ? MCAUSE_ST_MISALIGN
                                                             : MCAUSE_LD_MISALIGN;
            trap_info_o.mtval  = lsu_i.addr;
          end
        end
      end
      REQ: begin
        lsu_bp_o = 1'b1;
        if (dreq_ready_i) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        lsu_bp_o = 1'b1;
        if (rsp_hit) begin
          state_nxt = DONE;
        end
      end
      default: begin
        // DONE: one unstalled cycle lets execute advance past the memory op
        state_nxt = IDLE;
        if (err_ff) begin
          lsu_trap_o         = 1'b1;
          trap_info_o.mcause = req_ff.we ? MCAUSE_ST_FAULT : MCAUSE_LD_FAULT;
          trap_info_o.mtval  = req_ff.addr;
        end
      end
    endcase
  end

  // Request capture, timeout counter, response latch and write-back qualifiers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ff       <= '0;
      cnt_ff       <= '0;
      err_ff       <= 1'b0;
      load_wb_ff   <= 1'b0;
      kill_ff      <= 1'b0;
      load_data_ff <= '0;
    end else begin
      // Both flags are single-cycle: they qualify the instruction entering WB next cycle
      load_wb_ff <= (state_ff == DONE) && !req_ff.we && !err_ff;
      kill_ff    <= lsu_trap_o;

      if (state_ff == IDLE && op_vld && op_aligned) begin
        req_ff.addr  <= lsu_i.addr;
        req_ff.we    <= (lsu_i.op_typ == LSU_STORE);
        req_ff.wdata <= op_wdata;
        req_ff.strb  <= op_strb;
        req_ff.width <= lsu_i.width;
      end

      if (state_ff == RESP) begin
        cnt_ff <= cnt_ff + 1'b1;
      end else begin
        cnt_ff <= '0;
      end

      if (state_ff == RESP && rsp_hit) begin
        err_ff       <= rsp_err;
        load_data_ff <= ld_ext;
      end
    end
  end

  assign dreq_valid_o = (state_ff == REQ);
  assign dreq_addr_o  = {req_ff.addr[31:2], 2'b00};
  assign dreq_we_o    = req_ff.we;
  assign dreq_wdata_o = req_ff.wdata;
  assign dreq_strb_o  = req_ff.strb;

  assign wb_value_o = load_wb_ff ? load_data_ff : ex_mem_wb_i.result;
  assign rf_wdata_o = wb_value_o;
  assign rf_waddr_o = ex_mem_wb_i.rd_addr;
  assign rf_we_o    = ex_mem_wb_i.we_rd && (ex_mem_wb_i.rd_addr != '0) && !kill_ff;

endmodule

// File: tb/tb_mem_wb_lsu.sv
// Bench for mem_wb_lsu: table of ops run through a small EX/bus model, scoreboard monitors on bus/RF/trap.
// Expected request, RF write and trap records are queued when an op is driven and popped at the DUT.
// Also covers reset mid-transaction and the write-back flag clearing after use.
module tb_mem_wb_lsu;
  import mem_wb_lsu_pkg::*;

  logic         clk;
  logic         rst;
  s_ex_mem_wb_t ex_mem_wb_i;
  s_lsu_op_t    lsu_i;
  logic         lsu_bp_o;
  rdata_t       wb_value_o;
  logic         rf_we_o;
  raddr_t       rf_waddr_o;
  rdata_t       rf_wdata_o;
  logic         dreq_valid_o;
  logic         dreq_ready_i;
  logic [31:0]  dreq_addr_o;
  logic         dreq_we_o;
  logic [31:0]  dreq_wdata_o;
  logic [3:0]   dreq_strb_o;
  logic         drsp_valid_i;
  logic [31:0]  drsp_rdata_i;
  logic         drsp_err_i;
  logic         lsu_trap_o;
  s_trap_info_t trap_info_o;

  mem_wb_lsu #(.TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_mem_wb_i  (ex_mem_wb_i),
    .lsu_i        (lsu_i),
    .lsu_bp_o     (lsu_bp_o),
    .wb_value_o   (wb_value_o),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .dreq_valid_o (dreq_valid_o),
    .dreq_ready_i (dreq_ready_i),
    .dreq_addr_o  (dreq_addr_o),
    .dreq_we_o    (dreq_we_o),
    .dreq_wdata_o (dreq_wdata_o),
    .dreq_strb_o  (dreq_strb_o),
    .drsp_valid_i (drsp_valid_i),
    .drsp_rdata_i (drsp_rdata_i),
    .drsp_err_i   (drsp_err_i),
    .lsu_trap_o   (lsu_trap_o),
    .trap_info_o  (trap_info_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    lsu_op_typ_t op;
    lsu_width_t  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        resp;
    logic        early;
    int          rdy_wait;
    raddr_t      rd;
    logic        exp_req;
    logic [31:0] exp_daddr;
    logic [31:0] exp_dwdata;
    logic [3:0]  exp_strb;
    logic        exp_rf;
    logic [31:0] exp_val;
    logic        exp_trap;
    logic [31:0] exp_mcause;
    int          exp_bp;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } exp_req_t;

  typedef struct packed {
    raddr_t addr;
    rdata_t data;
  } exp_rf_t;

  exp_req_t     req_q[$];
  exp_rf_t      rf_q[$];
  s_trap_info_t trap_q[$];
  vec_t         vecs[$];

  exp_req_t     mon_req;
  exp_rf_t      mon_rf;
  s_trap_info_t mon_trap;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_idx = -1;

  function automatic void chk(input string nm, input int idx, input logic [31:0] got,
                              input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d] got=%h expected=%h", nm, idx, got, exp);
    end
  endfunction

  function automatic void bad(input string nm, input int idx, input logic [31:0] got);
    n_tests++;
    n_fail++;
    $display("FAIL %s [vec %0d] observed=%h with nothing expected", nm, idx, got);
  endfunction

  function automatic logic any_out();
    return |{lsu_bp_o, wb_value_o, rf_we_o, rf_waddr_o, rf_wdata_o, dreq_valid_o,
             dreq_addr_o, dreq_we_o, dreq_wdata_o, dreq_strb_o, lsu_trap_o, trap_info_o};
  endfunction

  // Scoreboard monitors: bus request, RF write and trap, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      if (dreq_valid_o) begin
        if (req_q.size() == 0) begin
          bad("unexpected_dreq", cur_idx, dreq_addr_o);
        end else begin
          mon_req = req_q[0];
          chk("dreq_addr", cur_idx, dreq_addr_o, mon_req.addr);
          chk("dreq_we", cur_idx, 32'(dreq_we_o), 32'(mon_req.we));
          if (mon_req.we) begin
            chk("dreq_wdata", cur_idx, dreq_wdata_o, mon_req.wdata);
            chk("dreq_strb", cur_idx, 32'(dreq_strb_o), 32'(mon_req.strb));
          end
          if (dreq_ready_i) mon_req = req_q.pop_front();
        end
      end
      if (rf_we_o) begin
        if (rf_q.size() == 0) begin
          bad("unexpected_rf_we", cur_idx, 32'(rf_waddr_o));
        end else begin
          mon_rf = rf_q.pop_front();
          chk("rf_waddr", cur_idx, 32'(rf_waddr_o), 32'(mon_rf.addr));
          chk("rf_wdata", cur_idx, rf_wdata_o, mon_rf.data);
          chk("wb_value", cur_idx, wb_value_o, mon_rf.data);
        end
      end
      if (lsu_trap_o) begin
        if (trap_q.size() == 0) begin
          bad("unexpected_trap", cur_idx, trap_info_o.mcause);
        end else begin
          mon_trap = trap_q.pop_front();
          chk("trap_mcause", cur_idx, trap_info_o.mcause, mon_trap.mcause);
          chk("trap_mtval", cur_idx, trap_info_o.mtval, mon_trap.mtval);
        end
      end
    end
  end

  // Present one op as execute would, play the bus side, then advance EX into WB
  task automatic run_vec(input vec_t v, input int idx);
    int bp_cnt  = 0;
    int rdy_cnt = 0;
    bit acc     = 1'b0;
    bit fin     = 1'b0;
    cur_idx     = idx;
    lsu_i       = '{op_typ: v.op, width: v.width, addr: v.addr, wdata: v.wdata};
    ex_mem_wb_i = '0;
    if (v.exp_req)
      req_q.push_back('{addr: v.exp_daddr, we: (v.op == LSU_STORE), wdata: v.exp_dwdata,
                        strb: v.exp_strb});
    if (v.exp_trap) trap_q.push_back('{mcause: v.exp_mcause, mtval: v.addr});
    for (int c = 0; c < 60 && !fin; c++) begin
      dreq_ready_i = dreq_valid_o && (rdy_cnt >= v.rdy_wait);
      drsp_valid_i = (acc && v.resp) || (v.early && dreq_valid_o && !dreq_ready_i);
      drsp_rdata_i = acc ? v.rdata : 32'h0BAD_0BAD;
      drsp_err_i   = acc ? v.err : 1'b1;
      acc          = dreq_valid_o && dreq_ready_i;
      if (dreq_valid_o) rdy_cnt++;
      @(negedge clk);
      if (lsu_bp_o) bp_cnt++;
      else fin = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!fin) bad("txn_cycle_budget", idx, 32'(bp_cnt));
    chk("bp_cycles", idx, 32'(bp_cnt), 32'(v.exp_bp));
    dreq_ready_i = 1'b0;
    drsp_valid_i = 1'b0;
    drsp_err_i   = 1'b0;
    drsp_rdata_i = '0;
    lsu_i        = '0;
    ex_mem_wb_i  = '{result: (v.op == NO_LSU) ? v.wdata : 32'h5555_5555,
                     rd_addr: v.rd, we_rd: (v.op != LSU_STORE)};
    if (v.exp_rf) rf_q.push_back('{addr: v.rd, data: v.exp_val});
    @(negedge clk);
    chk("rf_we_cycle", idx, 32'(rf_we_o), 32'(v.exp_rf));
    @(posedge clk);
    #1;
    ex_mem_wb_i = '{result: 32'hA5A5_0000 + 32'(idx), rd_addr: 5'd0, we_rd: 1'b0};
    @(negedge clk);
    chk("wb_after_use", idx, wb_value_o, 32'hA5A5_0000 + 32'(idx));
    @(posedge clk);
    #1;
    ex_mem_wb_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    ex_mem_wb_i  = '0;
    lsu_i        = '0;
    dreq_ready_i = 1'b0;
    drsp_valid_i = 1'b0;
    drsp_rdata_i = '0;
    drsp_err_i   = 1'b0;

    //              op         width   addr        wdata         rdata         err   resp  early rw rd     req   daddr       dwdata        strb  rf    val           trap  mcause bp
    vecs.push_back('{LSU_LOAD,  LSU_W,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 0, 5'd5,  1'b1, 32'h100, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0, 3});
    vecs.push_back('{LSU_LOAD,  LSU_B,  32'h103, 32'h0,        32'h80000000, 1'b0, 1'b1, 1'b0, 0, 5'd6,  1'b1, 32'h100, 32'h0,        4'h0, 1'b1, 32'hFFFFFF80, 1'b0, 32'd0, 3});
    vecs.push_back('{LSU_LOAD,  LSU_BU, 32'h103, 32'h0,        32'h80000000, 1'b0, 1'b1, 1'b0, 0, 5'd6,  1'b1, 32'h100, 32'h0,        4'h0, 1'b1, 32'h00000080, 1'b0, 32'd0, 3});
    vecs.push_back('{LSU_LOAD,  LSU_H,  32'h102, 32'h0,        32'h8001FFFF, 1'b0, 1'b1, 1'b0, 0, 5'd8,  1'b1, 32'h100, 32'h0,        4'h0, 1'b1, 32'hFFFF8001, 1'b0, 32'd0, 3});
    vecs.push_back('{LSU_LOAD,  LSU_HU, 32'h102, 32'h0,        32'h8001FFFF, 1'b0, 1'b1, 1'b0, 0, 5'd8,  1'b1, 32'h100, 32'h0,        4'h0, 1'b1, 32'h00008001, 1'b0, 32'd0, 3});
    vecs.push_back('{LSU_LOAD,  LSU_B,  32'h101, 32'h0,        32'h11223344, 1'b0, 1'b1, 1'b0, 0, 5'd10, 1'b1, 32'h100, 32'h0,        4'h0, 1'b1, 32'h00000033, 1'b0, 32'd0, 3});
    vecs.push_back('{LSU_STORE, LSU_B,  32'h202, 32'h000000AB, 32'h0,        1'b0, 1'b1, 1'b0, 0, 5'd0,  1'b1, 32'h200, 32'hABABABAB, 4'h4, 1'b0, 32'h0,        1'b0, 32'd0, 3});
    vecs.push_back('{LSU_STORE, LSU_H,  32'h206, 32'h1234CDEF, 32'h0,        1'b0, 1'b1, 1'b0, 0, 5'd0,  1'b1, 32'h204, 32'hCDEFCDEF, 4'hC, 1'b0, 32'h0,        1'b0, 32'd0, 3});
    vecs.push_back('{LSU_STORE, LSU_W,  32'h300, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 1'b1, 5, 5'd0,  1'b1, 32'h300, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0, 32'd0, 8});
    vecs.push_back('{LSU_LOAD,  LSU_W,  32'h101, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 0, 5'd5,  1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 32'd4, 0});
    vecs.push_back('{LSU_STORE, LSU_H,  32'h201, 32'h00001234, 32'h0,        1'b0, 1'b1, 1'b0, 0, 5'd0,  1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 32'd6, 0});
    vecs.push_back('{LSU_LOAD,  LSU_H,  32'h103, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 0, 5'd4,  1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 32'd4, 0});
    vecs.push_back('{LSU_STORE, LSU_W,  32'h304, 32'h11111111, 32'h0,        1'b1, 1'b1, 1'b0, 0, 5'd0,  1'b1, 32'h304, 32'h11111111, 4'hF, 1'b0, 32'h0,        1'b1, 32'd7, 3});
    vecs.push_back('{LSU_LOAD,  LSU_W,  32'h308, 32'h0,        32'h12121212, 1'b1, 1'b1, 1'b0, 0, 5'd9,  1'b1, 32'h308, 32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 32'd5, 3});
    vecs.push_back('{LSU_LOAD,  LSU_W,  32'h40C, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 0, 5'd11, 1'b1, 32'h40C, 32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 32'd5, 11});
    vecs.push_back('{NO_LSU,    LSU_W,  32'h0,   32'h12345678, 32'h0,        1'b0, 1'b1, 1'b0, 0, 5'd7,  1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h12345678, 1'b0, 32'd0, 0});
    vecs.push_back('{NO_LSU,    LSU_W,  32'h0,   32'h0BADBEEF, 32'h0,        1'b0, 1'b1, 1'b0, 0, 5'd0,  1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'd0, 0});
    vecs.push_back('{LSU_LOAD,  LSU_W,  32'h100, 32'h0,        32'h77777777, 1'b0, 1'b1, 1'b0, 0, 5'd0,  1'b1, 32'h100, 32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 32'd0, 3});

    #12;
    chk("reset_outputs", -1, 32'(any_out()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while waiting for a response: bus request must drop at once, no trap afterwards
    cur_idx = 200;
    lsu_i   = '{op_typ: LSU_LOAD, width: LSU_W, addr: 32'h500, wdata: 32'h0};
    req_q.push_back('{addr: 32'h500, we: 1'b0, wdata: 32'h0, strb: 4'h0});
    @(posedge clk);
    #1;
    dreq_ready_i = 1'b1;
    @(posedge clk);
    #1;
    dreq_ready_i = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_in_resp", 200, 32'(lsu_bp_o), 32'd1);
    #2;
    rst   = 1'b0;
    lsu_i = '0;
    #1;
    chk("reset_mid_outputs", 200, 32'(any_out()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_release", 200, 32'(any_out()), 32'd0);
    @(posedge clk);
    #1;
    run_vec(vecs[0], 100);

    repeat (3) @(posedge clk);
    chk("req_q_drained", -1, 32'(req_q.size()), 32'd0);
    chk("rf_q_drained", -1, 32'(rf_q.size()), 32'd0);
    chk("trap_q_drained", -1, 32'(trap_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
